prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Host-side initiator for the processor's program-load interface (`mem_write`, `PC_reset`, `instr`, `portin`).
- Accepts up to 16 program bytes from a host over a valid/ready byte stream and buffers them.
- Halts the processor, bursts exactly 16 words into program memory on consecutive cycles so the processor PC wraps back to 0, then releases the processor to run from address 0.

Parameters:
- DEPTH, 16: program memory words; fixed by the 4-bit PC. Only 16 is supported.
- PAD_WORD, 8'h90: word written to every location not supplied by the host. Default is opcode 1001 (jump), target 0.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- in_valid  in  1  host byte valid.
- in_ready  out  1  loader accepts a byte this cycle.
- in_data  in  8  program byte; [7:4] opcode, [3:0] operand.
- in_last  in  1  marks the final host byte; qualified by in_valid & in_ready.
- pc_reset  out  1  drives processor `PC_reset` (active-high).
- mem_write  out  1  drives processor `mem_write`.
- instr  out  4  drives processor `instr` (word[7:4]).
- portin  out  4  drives processor `portin` (word[3:0]).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the load completes.

Behaviour:
- All outputs are registered.
- Reset values (rst_n low at posedge):
  - state=IDLE, pc_reset=1, mem_write=0, instr=0, portin=0, in_ready=0, busy=0, done=0, fill count=0.
  - Buffer contents are don't-care.
- After reset, the first IDLE cycle drives pc_reset=0.
- FSM states: IDLE, FILL, HALT, BURST, RELEASE.
- IDLE:
  - pc_reset=0, in_ready=0.
  - start=1 → FILL. Fill count cleared. pc_reset=1 from the next cycle.
- FILL:
  - pc_reset=1, in_ready=1.
  - Each in_valid & in_ready writes buf[cnt]=in_data and increments cnt (5-bit).
  - Leave for HALT when the accepted byte has in_last=1, or when it is the 16th byte (cnt becomes 16).
  - in_last is ignored on all other cycles.
  - in_ready drops in the cycle after the terminating byte.
  - Locations cnt..15 read as PAD_WORD during BURST. The implementation may pad during HALT or select on index.
  - in_valid low holds in FILL indefinitely.
- HALT:
  - Exactly 2 cycles, pc_reset=1, mem_write=0.
  - Guarantees the processor PC=0 and jmp_enable=0 before the burst.
- BURST:
  - Exactly 16 consecutive cycles with pc_reset=0, mem_write=1.
  - In burst cycle k (k=0..15): {instr,portin} = (k<cnt) ? buf[k] : PAD_WORD.
  - The processor writes PM[k] at posedge and advances its PC on negedge. No gaps are permitted.
- RELEASE:
  - 1 cycle, mem_write=0, pc_reset=1. Forces processor PC=0.
  - Next cycle: IDLE with pc_reset=0 and done=1 for exactly that one cycle.
- instr/portin hold their last value outside BURST. They are don't-care to the processor, but the bench checks them only in BURST.
- start outside IDLE is ignored; no queueing.
- rst_n low in any state (including mid-BURST) returns all outputs to reset values on that posedge.
  - No further mem_write pulses occur.
  - The processor is left held (pc_reset=1) until the first IDLE cycle.
- busy=1 in FILL, HALT, BURST and RELEASE. Total latency from the terminating byte to done is 2+16+1+1=20 cycles.

Test Plan:
- Full load: start, 16 bytes 8'h61,8'h73,8'h80,...(k-indexed) back-to-back, in_last on 16th → HALT 2 cycles with pc_reset=1; then 16 cycles mem_write=1, {instr,portin}=byte k in cycle k; RELEASE pc_reset=1; done pulses 20 cycles after the last byte. Processor then executes: LDI 1 then OUT gives portout=4'h1.
- Short load: 3 bytes {8'h65,8'h70,8'h90}, in_last on 3rd → burst words 0..2 equal the bytes, words 3..15 = 8'h90; cnt=3.
- Host stalls: in_valid toggles 1,0,0,1... over 5 bytes → only valid&ready bytes stored, in order; FILL persists during gaps; pc_reset stays 1 throughout.
- Overrun: 20 bytes offered with no in_last → exactly 16 accepted, in_ready=0 from the cycle after the 16th byte, bytes 17-20 never stored.
- start during BURST → ignored, and burst length stays 16. rst_n low at burst cycle 7 → mem_write=0 and pc_reset=1 next cycle, busy=0; later start/reload completes normally.
- Single-byte load with in_last on the first byte → 1 data word plus 15 PAD_WORD entries; done asserted once.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: buffers up to 16 host bytes, halts the processor, bursts all 16 program words, then releases it.
module prog_loader #(
    parameter int          DEPTH    = 16,
    parameter logic [7:0]  PAD_WORD = 8'h90
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       pc_reset,
    output logic       mem_write,
    output logic [3:0] instr,
    output logic [3:0] portin,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, FILL, HALT, BURST, RELEASE} state_t;

    state_t     state_q, state_d;
    logic [7:0] mem_q [DEPTH];
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] word_d, word_q;
    logic       pc_reset_q, mem_write_q, in_ready_q, busy_q, done_q;
    logic       acc;

    assign acc    = (state_q == FILL) && in_valid && in_ready_q;
    assign word_d = ({1'b0, idx_d} < cnt_q) ? mem_q[idx_d] : PAD_WORD;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                state_d = start ? FILL : IDLE;
                cnt_d   = start ? 5'd0 : cnt_q;
            end
            FILL: begin
                cnt_d   = acc ? cnt_q + 5'd1 : cnt_q;
                state_d = (acc && (in_last || cnt_q == 5'(DEPTH - 1))) ? HALT : FILL;
                idx_d   = 4'd0;
            end
            // idx_q counts the two halt cycles, then the burst index
            HALT: begin
                state_d = (idx_q == 4'd1) ? BURST : HALT;
                idx_d   = (idx_q == 4'd1) ? 4'd0 : idx_q + 4'd1;
            end
            BURST: begin
                state_d = (idx_q == 4'(DEPTH - 1)) ? RELEASE : BURST;
                idx_d   = idx_q + 4'd1;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            idx_q       <= 4'd0;
            pc_reset_q  <= 1'b1;
            mem_write_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            word_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pc_reset_q  <= state_d inside {FILL, HALT, RELEASE};
            mem_write_q <= state_d == BURST;
            in_ready_q  <= state_d == FILL;
            busy_q      <= state_d != IDLE;
            done_q      <= state_q == RELEASE;
            word_q      <= (state_d == BURST) ? word_d : word_q;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) mem_q[cnt_q[3:0]] <= in_data;
    end

    assign pc_reset  = pc_reset_q;
    assign mem_write = mem_write_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign instr     = word_q[7:4];
    assign portin    = word_q[3:0];
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench; stimulus queues expected burst words, a negedge monitor checks them.
module tb_prog_loader;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready, pc_reset, mem_write, busy, done;
    logic [3:0] instr, portin;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .pc_reset(pc_reset), .mem_write(mem_write),
        .instr(instr), .portin(portin), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] vec[20];
    int cyc = 0, acc_n = 0, last_acc = 0, wr_n = 0, first_wr = 0, done_n = 0, done_cyc = 0;
    logic prev_mw = 1'b0, prev_done = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
        end
    endtask

    // Monitor: counts handshakes, pops the scoreboard on every write, checks pc_reset/done invariants.
    always @(negedge clk) begin
        cyc++;
        if (in_valid && in_ready) begin
            acc_n++;
            last_acc = cyc;
        end
        if (mem_write) begin
            if (!prev_mw) first_wr = cyc;
            wr_n++;
            chk("burst_pc_reset", int'(pc_reset), 0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL burst_extra_word: got 0x%0h with empty scoreboard", {instr, portin});
            end else chk("burst_word", int'({instr, portin}), int'(exp_q.pop_front()));
        end else if (busy) chk("held_pc_reset", int'(pc_reset), 1);
        if (done) begin
            if (prev_done) begin
                tests++;
                fails++;
                $display("FAIL done_width: done high on consecutive cycles");
            end
            done_n++;
            done_cyc = cyc;
        end
        prev_mw   = mem_write;
        prev_done = done;
    end

    task automatic push_exp(input int m);
        for (int k = 0; k < 16; k++) exp_q.push_back(k < m ? vec[k] : 8'h90);
    endtask

    task automatic send(input int n, input int last_i, input int gap);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = vec[i];
            in_last  = (i == last_i);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic run_load(input int n, input int last_i, input int gap, input int m, input bit start_burst);
        int a0, w0, d0, t;
        a0 = acc_n; w0 = wr_n; d0 = done_n;
        push_exp(m);
        send(n, last_i, gap);
        if (start_burst) begin
            t = 0;
            while (!mem_write && t < 40) begin @(negedge clk); t++; end
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        t = 0;
        while (done_n == d0 && t < 60) begin @(negedge clk); t++; end
        chk("done_seen", done_n - d0, 1);
        chk("accepted", acc_n - a0, m);
        chk("halt_len", first_wr - last_acc, 3);
        chk("done_latency", done_cyc - last_acc, 20);
        chk("burst_len", wr_n - w0, 16);
        repeat (3) @(negedge clk);
        chk("idle_after", int'(busy), 0);
        chk("one_done", done_n - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int t, w0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc_reset", int'(pc_reset), 1);
        chk("rst_mem_write", int'(mem_write), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_word", int'({instr, portin}), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_pc_reset", int'(pc_reset), 0);
        @(posedge clk); #1;
        // full load
        vec[0] = 8'h61; vec[1] = 8'h73; vec[2] = 8'h80;
        for (int k = 3; k < 20; k++) vec[k] = 8'(k * 8'h11);
        run_load(16, 15, 0, 16, 1'b0);
        // short load
        vec[0] = 8'h65; vec[1] = 8'h70; vec[2] = 8'h90;
        run_load(3, 2, 0, 3, 1'b0);
        // host stalls
        vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44; vec[4] = 8'h55;
        run_load(5, 4, 2, 5, 1'b0);
        // overrun: 20 bytes, no in_last
        for (int k = 0; k < 20; k++) vec[k] = 8'hA0 + 8'(k);
        run_load(20, -1, 0, 16, 1'b0);
        // start during burst is ignored
        for (int k = 0; k < 16; k++) vec[k] = 8'h40 + 8'(k);
        run_load(16, 15, 0, 16, 1'b1);
        // reset at burst cycle 7
        w0 = wr_n;
        push_exp(16);
        send(16, 15, 0);
        t = 0;
        while (!mem_write && t < 40) begin @(negedge clk); t++; end
        chk("burst_start_seen", int'(mem_write), 1);
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_mem_write", int'(mem_write), 0);
        chk("mid_rst_pc_reset", int'(pc_reset), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_writes", wr_n - w0, 8);
        chk("mid_rst_left", exp_q.size(), 8);
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_idle_pc", int'(pc_reset), 0);
        @(posedge clk); #1;
        vec[0] = 8'h65; vec[1] = 8'h70; vec[2] = 8'h90;
        run_load(3, 2, 0, 3, 1'b0);
        // single byte
        vec[0] = 8'h3C;
        run_load(1, 0, 0, 1, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
